// File: rtl/bg_scan_pkg.sv
// Shared types and default geometry for the background scan sequencer.
package bg_scan_pkg;

  localparam int DEF_SRC_W  = 80;
  localparam int DEF_SRC_H  = 60;
  localparam int DEF_SCALE  = 4;
  localparam int DEF_ADDR_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
  } pix_tag_t;

  localparam int PIX_TAG_W = $bits(pix_tag_t);

endpackage

// File: rtl/bg_scan_fifo.sv
// Two-entry synchronous FIFO carrying a pixel and its frame/line tags; reset flushes it.
module bg_scan_fifo
  import bg_scan_pkg::*;
#(
  parameter int W = PIX_TAG_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         wr_ptr;
  logic         rd_ptr;

  // The producer throttles itself on count, so push never arrives while full.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= din;
        else        slot0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = rd_ptr ? slot1 : slot0;

endmodule

// File: rtl/background_scan_ctrl.sv
// Walks the background memory once per frame, replicating each source pixel SCALE x SCALE.
// Define BG_SCAN_CONTINUOUS_EN to run frames back-to-back without a new start.
module background_scan_ctrl
  import bg_scan_pkg::*;
#(
  parameter int SRC_W  = DEF_SRC_W,
  parameter int SRC_H  = DEF_SRC_H,
  parameter int SCALE  = DEF_SCALE,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  input  logic [15:0]       mem_readdata,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [1:0]        state_dbg
);

`ifdef BG_SCAN_CONTINUOUS_EN
  localparam bit CONTINUOUS = 1'b1;
`else
  localparam bit CONTINUOUS = 1'b0;
`endif

  localparam int PX_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int SX_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int SY_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam logic [PX_W-1:0] PX_MAX = PX_W'(SCALE - 1);
  localparam logic [SX_W-1:0] SX_MAX = SX_W'(SRC_W - 1);
  localparam logic [SY_W-1:0] SY_MAX = SY_W'(SRC_H - 1);

  scan_state_t       state, state_next;
  logic [PX_W-1:0]   px, py;
  logic [SX_W-1:0]   sx;
  logic [SY_W-1:0]   sy;
  logic [ADDR_W-1:0] row_base;
  logic              inflight, inflight_sof, inflight_eol;
  logic [1:0]        last_pending;
  logic              done_q;
  logic [1:0]        fifo_count;
  pix_tag_t          push_tag, head;
  logic              pop, issue, last_issue, issue_sof, issue_eol;
  logic [2:0]        occ;

  // Pixel stream: a pixel transfers in any cycle with pix_valid & pix_ready; while
  // pix_valid is high and pix_ready low, pix_data/sof/eol/valid stay unchanged.
  assign pix_valid = (fifo_count != 2'd0);
  assign pop       = pix_valid & pix_ready;
  assign pix_data  = pix_valid ? head.data : 16'd0;
  assign pix_sof   = pix_valid & head.sof;
  assign pix_eol   = pix_valid & head.eol;

  // Slots still claimed after this cycle's pop; a new read needs one free slot.
  assign occ        = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == ST_RUN) && (occ <= 3'd1);
  assign last_issue = issue && (px == PX_MAX) && (sx == SX_MAX) &&
                      (py == PX_MAX) && (sy == SY_MAX);
  assign issue_sof  = (px == '0) && (sx == '0) && (py == '0) && (sy == '0);
  assign issue_eol  = (px == PX_MAX) && (sx == SX_MAX);

  assign mem_chipselect = issue;
  assign mem_address    = row_base + ADDR_W'(sx);
  assign push_tag       = '{data: mem_readdata, sof: inflight_sof, eol: inflight_eol};

  assign done      = done_q;
  assign busy      = (state == ST_RUN) || ((state == ST_DRAIN) && !done_q);
  assign state_dbg = state;

  bg_scan_fifo #(.W(PIX_TAG_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .pop   (pop),
    .din   (push_tag),
    .dout  (head),
    .count (fifo_count)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (last_issue && !CONTINUOUS) state_next = ST_DRAIN;
      ST_DRAIN: if (done_q) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      px           <= '0;
      sx           <= '0;
      py           <= '0;
      sy           <= '0;
      row_base     <= '0;
      inflight     <= 1'b0;
      inflight_sof <= 1'b0;
      inflight_eol <= 1'b0;
      last_pending <= 2'd0;
      done_q       <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (issue) begin
        inflight_sof <= issue_sof;
        inflight_eol <= issue_eol;
      end
      // Track how many pops remain until the frame's final pixel leaves.
      done_q <= pop && (last_pending == 2'd1);
      if (last_issue)
        last_pending <= occ[1:0] + 2'd1;
      else if (pop && (last_pending != 2'd0))
        last_pending <= last_pending - 2'd1;

      if (state == ST_IDLE) begin
        px       <= '0;
        sx       <= '0;
        py       <= '0;
        sy       <= '0;
        row_base <= '0;
      end else if (issue) begin
        if (px == PX_MAX) begin
          px <= '0;
          if (sx == SX_MAX) begin
            sx <= '0;
            if (py == PX_MAX) begin
              py <= '0;
              if (sy == SY_MAX) begin
                sy       <= '0;
                row_base <= '0;
              end else begin
                sy       <= sy + SY_W'(1);
                row_base <= row_base + ADDR_W'(SRC_W);
              end
            end else begin
              py <= py + PX_W'(1);
            end
          end else begin
            sx <= sx + SX_W'(1);
          end
        end else begin
          px <= px + PX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_background_scan_ctrl.sv
// Directed bench for background_scan_ctrl on a reduced 8x6 source, SCALE 4 geometry.
module tb_background_scan_ctrl;
  import bg_scan_pkg::*;

  localparam int SRC_W  = 8;
  localparam int SRC_H  = 6;
  localparam int SCALE  = 4;
  localparam int ADDR_W = 13;
  localparam int OUT_W  = SRC_W * SCALE;
  localparam int FRAME  = OUT_W * SRC_H * SCALE;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic [15:0]       mem_readdata = 16'd0;
  logic [15:0]       pix_data;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic              pix_sof, pix_eol;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hs_count = 0;
  int done_count = 0;
  int last_hs_cyc = -10;
  int sof2_gap = -1;
  logic [17:0] exp_q[$];
  logic [15:0] got_data [FRAME];
  logic        got_sof  [FRAME];
  logic        got_eol  [FRAME];
  logic        stall_prev = 1'b0;
  logic [17:0] prev_out;

  background_scan_ctrl #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_readdata(mem_readdata), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .state_dbg(state_dbg)
  );

  // Clock / reset, memory model mem[i] = i with one-cycle read latency
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_chipselect) mem_readdata <= {3'b000, mem_address};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [17:0] exp_pix(input int k);
    int ox, oy;
    ox = k % OUT_W;
    oy = k / OUT_W;
    return {16'((oy / SCALE) * SRC_W + ox / SCALE), k == 0, ox == OUT_W - 1};
  endfunction

  task automatic push_frame();
    for (int k = 0; k < FRAME; k++) exp_q.push_back(exp_pix(k));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    hs_count   = 0;
    done_count = 0;
    sof2_gap   = -1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_sof"},   32'(pix_sof), 32'd0);
    check({tag, "_eol"},   32'(pix_eol), 32'd0);
    check({tag, "_cs"},    32'(mem_chipselect), 32'd0);
    check({tag, "_addr"},  32'(mem_address), 32'd0);
    check({tag, "_data"},  32'(pix_data), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) begin
      n_checks++;
      $error("FAIL %s_timeout observed=no_done expected=done_within_%0d", tag, budget);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard / monitor: sampled on the falling edge
  always @(negedge clk) begin
    logic [17:0] e;
    if (!reset) begin
      if (stall_prev)
        check("stall_stable", 32'({pix_valid, pix_data, pix_sof, pix_eol}), 32'({1'b1, prev_out}));
      check("fifo_count_le2", 32'(dut.u_fifo.count <= 2'd2), 32'd1);
      if (done) begin
        done_count++;
        check("done_latency", 32'(cyc), 32'(last_hs_cyc + 1));
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $error("FAIL unexpected_pixel observed=%0h expected=none", pix_data);
        end else begin
          e = exp_q.pop_front();
          check("pixel", 32'({pix_data, pix_sof, pix_eol}), 32'(e));
        end
        if (hs_count < FRAME) begin
          got_data[hs_count] = pix_data;
          got_sof[hs_count]  = pix_sof;
          got_eol[hs_count]  = pix_eol;
        end
        if (hs_count == FRAME) sof2_gap = cyc - last_hs_cyc;
        hs_count++;
        last_hs_cyc = cyc;
      end
    end
    stall_prev = !reset && pix_valid && !pix_ready;
    prev_out   = {pix_data, pix_sof, pix_eol};
  end

  initial begin
    #1000000;
    n_checks++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

`ifdef BG_SCAN_CONTINUOUS_EN
    // Two back-to-back frames, no gap, done each frame with busy held
    clear_stats();
    repeat (3) push_frame();
    pix_ready = 1'b1;
    pulse_start();
    n = 0;
    while (done_count < 2 && n < 3 * FRAME) begin
      if (done) check("cont_busy_at_done", 32'(busy), 32'd1);
      tick();
      n++;
    end
    check("cont_done_count", 32'(done_count), 32'd2);
    check("cont_sof2_gap", 32'(sof2_gap), 32'd1);
    reset = 1'b1;
    tick();
    check_idle_outputs("cont_reset");
    reset = 1'b0;
    exp_q.delete();
    tick();
`else
    // Latency and full frame with pix_ready high
    clear_stats();
    push_frame();
    pix_ready = 1'b1;
    pulse_start();
    check("lat_c1_busy", 32'(busy), 32'd1);
    check("lat_c1_cs", 32'(mem_chipselect), 32'd1);
    check("lat_c1_addr", 32'(mem_address), 32'd0);
    check("lat_c1_valid", 32'(pix_valid), 32'd0);
    tick();
    check("lat_c2_valid", 32'(pix_valid), 32'd0);
    check("lat_c2_cs", 32'(mem_chipselect), 32'd1);
    tick();
    check("lat_c3_valid", 32'(pix_valid), 32'd1);
    check("lat_c3_sof", 32'(pix_sof), 32'd1);
    check("lat_c3_data", 32'(pix_data), 32'd0);
    wait_done(FRAME + 50, "frame_a");
    check("a_busy_at_done", 32'(busy), 32'd0);
    tick();
    check("a_hs_count", 32'(hs_count), 32'(FRAME));
    check("a_done_count", 32'(done_count), 32'd1);
    check("a_queue_empty", 32'(exp_q.size()), 32'd0);
    check("a_pix0", 32'(got_data[0]), 32'd0);
    check("a_pix3", 32'(got_data[3]), 32'd0);
    check("a_pix4", 32'(got_data[4]), 32'd1);
    check("a_eol30", 32'(got_eol[30]), 32'd0);
    check("a_eol31", 32'(got_eol[31]), 32'd1);
    check("a_line4_start", 32'(got_data[4 * OUT_W]), 32'd8);
    check("a_last_pix", 32'(got_data[FRAME - 1]), 32'd47);
    check("a_done_after", 32'(done), 32'd0);
    check("a_idle_state", 32'(state_dbg), 32'(ST_IDLE));

    // Random 50% backpressure
    clear_stats();
    push_frame();
    pix_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!done && n < 4 * FRAME) begin
      pix_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    tick();
    check("b_hs_count", 32'(hs_count), 32'(FRAME));
    check("b_done_count", 32'(done_count), 32'd1);
    check("b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame, then a clean frame
    clear_stats();
    push_frame();
    pix_ready = 1'b1;
    pulse_start();
    n = 0;
    while (hs_count < 300 && n < FRAME) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    check_idle_outputs("midreset");
    reset = 1'b0;
    exp_q.delete();
    tick();
    clear_stats();
    push_frame();
    pulse_start();
    wait_done(FRAME + 50, "frame_c");
    tick();
    check("c_first_pix", 32'(got_data[0]), 32'd0);
    check("c_first_sof", 32'(got_sof[0]), 32'd1);
    check("c_hs_count", 32'(hs_count), 32'(FRAME));

    // start while busy and coincident with done is ignored
    clear_stats();
    push_frame();
    pulse_start();
    n = 0;
    while (hs_count < 200 && n < FRAME) begin
      tick();
      n++;
    end
    pulse_start();
    wait_done(FRAME + 50, "frame_d");
    pulse_start();
    repeat (10) tick();
    check("d_busy", 32'(busy), 32'd0);
    check("d_valid", 32'(pix_valid), 32'd0);
    check("d_cs", 32'(mem_chipselect), 32'd0);
    check("d_done_count", 32'(done_count), 32'd1);
    check("d_hs_count", 32'(hs_count), 32'(FRAME));
    check("d_state", 32'(state_dbg), 32'(ST_IDLE));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
